// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers for the sync generator and the graphics blocks.
// Default mode is 640x480 @ 60 Hz with a 25 MHz pixel rate.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int CLK_DIV = 4;

    localparam int H_DISP  = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;

    localparam int V_DISP  = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam int FRAME_LINE = 500;

    // Inclusive pixel/line ranges where the sync pulses are asserted.
    localparam int H_SYNC_START = H_DISP + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISP + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/tick_div.sv
// Pixel-rate strobe: one-clk pulse every CLK_DIV system clocks, first pulse on the
// CLK_DIV-th cycle after reset release.
module tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int              CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign p_tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing master: pixel strobe, horizontal/vertical counters, registered sync and
// video flags, plus line and frame strobes for the game logic.
module vga_sync_gen
    import vga_pkg::coord_t;
    import vga_pkg::COORD_W;
    import vga_pkg::in_span;
#(
    parameter int CLK_DIV    = vga_pkg::CLK_DIV,
    parameter int H_DISP     = vga_pkg::H_DISP,
    parameter int H_FP       = vga_pkg::H_FP,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BP       = vga_pkg::H_BP,
    parameter int V_DISP     = vga_pkg::V_DISP,
    parameter int V_FP       = vga_pkg::V_FP,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BP       = vga_pkg::V_BP,
    parameter int FRAME_LINE = vga_pkg::FRAME_LINE
) (
    input  logic               clk,
    input  logic               reset,
    output logic               p_tick,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               video,
    output logic               hsync,
    output logic               vsync,
    output logic               line_tick,
    output logic               frame_tick
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISP);
    localparam coord_t V_VIS    = coord_t'(V_DISP);
    localparam coord_t HS_START = coord_t'(H_DISP + H_FP);
    localparam coord_t HS_END   = coord_t'(H_DISP + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_DISP + V_FP);
    localparam coord_t VS_END   = coord_t'(V_DISP + V_FP + V_SYNC - 1);
    localparam coord_t FRAME_Y  = coord_t'(FRAME_LINE);

    coord_t x_next;
    coord_t y_next;

    tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .p_tick(p_tick)
    );

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        x_next = pix_x;
        y_next = pix_y;
        if (p_tick) begin
            if (pix_x == H_LAST) begin
                x_next = '0;
                y_next = (pix_y == V_LAST) ? '0 : pix_y + 1'b1;
            end else begin
                x_next = pix_x + 1'b1;
            end
        end
    end

    // Flags are decoded from the next-state position so they line up with pix_x/pix_y.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_x <= '0;
            pix_y <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            video <= 1'b0;
        end else if (p_tick) begin
            pix_x <= x_next;
            pix_y <= y_next;
            hsync <= !in_span(x_next, HS_START, HS_END);
            vsync <= !in_span(y_next, VS_START, VS_END);
            video <= (x_next < H_VIS) && (y_next < V_VIS);
        end
    end

    assign line_tick  = p_tick && (pix_x == H_LAST);
    assign frame_tick = p_tick && (pix_x == '0) && (pix_y == FRAME_Y);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a reduced-timing instance (CLK_DIV=4) for frame-level behaviour
// and a default-timing instance (CLK_DIV=2) for line-level behaviour.
module tb_vga_sync_gen;

    typedef struct packed {
        logic       p_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       video;
        logic       hsync;
        logic       vsync;
        logic       line_tick;
        logic       frame_tick;
    } out_t;

    typedef struct packed {
        int d;
        int ht;
        int hdisp;
        int hs0;
        int hs1;
        int vt;
        int vdisp;
        int vs0;
        int vs1;
        int fl;
    } tim_t;

    typedef struct {
        int   k;
        out_t exp;
    } vec_t;

    // Small mode: 25 px/line (sync 18..21), 17 lines (sync 12..13), frame strobe on line 15.
    localparam tim_t T_S = '{d: 4, ht: 25, hdisp: 16, hs0: 18, hs1: 21,
                             vt: 17, vdisp: 10, vs0: 12, vs1: 13, fl: 15};
    localparam tim_t T_W = '{d: 2, ht: 800, hdisp: 640, hs0: 656, hs1: 751,
                             vt: 525, vdisp: 480, vs0: 490, vs1: 491, fl: 500};
    localparam out_t RST = '{p_tick: 1'b0, x: 10'd0, y: 10'd0, video: 1'b0, hsync: 1'b1,
                             vsync: 1'b1, line_tick: 1'b0, frame_tick: 1'b0};

    logic       clk = 1'b0;
    logic       rst_s, rst_w;
    logic       p_s, vid_s, hs_s, vs_s, lt_s, ft_s;
    logic       p_w, vid_w, hs_w, vs_w, lt_w, ft_w;
    logic [9:0] x_s, y_s, x_w, y_w;
    out_t       got_s, got_w;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .CLK_DIV(4), .H_DISP(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_DISP(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .FRAME_LINE(15)
    ) dut_s (
        .clk(clk), .reset(rst_s), .p_tick(p_s), .pix_x(x_s), .pix_y(y_s), .video(vid_s),
        .hsync(hs_s), .vsync(vs_s), .line_tick(lt_s), .frame_tick(ft_s)
    );

    vga_sync_gen #(
        .CLK_DIV(2)
    ) dut_w (
        .clk(clk), .reset(rst_w), .p_tick(p_w), .pix_x(x_w), .pix_y(y_w), .video(vid_w),
        .hsync(hs_w), .vsync(vs_w), .line_tick(lt_w), .frame_tick(ft_w)
    );

    assign got_s = {p_s, x_s, y_s, vid_s, hs_s, vs_s, lt_s, ft_s};
    assign got_w = {p_w, x_w, y_w, vid_w, hs_w, vs_w, lt_w, ft_w};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_out(input string name, input out_t got, input out_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got x=%0d y=%0d p=%b vid=%b hs=%b vs=%b lt=%b ft=%b, required x=%0d y=%0d p=%b vid=%b hs=%b vs=%b lt=%b ft=%b",
                      name, got.x, got.y, got.p_tick, got.video, got.hsync, got.vsync,
                      got.line_tick, got.frame_tick, exp.x, exp.y, exp.p_tick, exp.video,
                      exp.hsync, exp.vsync, exp.line_tick, exp.frame_tick);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, got, exp);
    endtask

    // Closed-form reference: k = clk edges since reset release. Pixel 0 of the first frame
    // after reset keeps video low because the flags only load on p_tick edges.
    function automatic out_t model(input tim_t t, input int k);
        out_t o;
        int   pix, x, y;
        pix          = k / t.d;
        x            = pix % t.ht;
        y            = (pix / t.ht) % t.vt;
        o.p_tick     = (k % t.d) == (t.d - 1);
        o.x          = 10'(x);
        o.y          = 10'(y);
        o.video      = (pix > 0) && (x < t.hdisp) && (y < t.vdisp);
        o.hsync      = !((x >= t.hs0) && (x <= t.hs1));
        o.vsync      = !((y >= t.vs0) && (y <= t.vs1));
        o.line_tick  = o.p_tick && (x == t.ht - 1);
        o.frame_tick = o.p_tick && (x == 0) && (y == t.fl);
        return o;
    endfunction

    function automatic out_t mk(input logic p, input int x, input int y, input logic vid,
                                input logic hs, input logic vs, input logic lt, input logic ft);
        return '{p_tick: p, x: 10'(x), y: 10'(y), video: vid, hsync: hs, vsync: vs,
                 line_tick: lt, frame_tick: ft};
    endfunction

    // Scoreboards: expectation pushed at each edge, compared at the following negedge.
    int   k_s = 0, k_w = 0;
    bit   sb_s = 1'b1, sb_w = 1'b1;
    out_t q_s[$], q_w[$];

    always @(posedge clk) begin
        if (!rst_s) k_s = 0;
        else        k_s = k_s + 1;
        if (sb_s) q_s.push_back(model(T_S, k_s));
        if (!rst_w) k_w = 0;
        else        k_w = k_w + 1;
        if (sb_w) q_w.push_back(model(T_W, k_w));
    end

    always @(negedge clk) begin
        out_t e;
        if (sb_s && q_s.size() > 0) begin
            e = q_s.pop_front();
            if (n_checks - n_pass < 30) check_out("sb_small", got_s, e);
        end
        if (sb_w && q_w.size() > 0) begin
            e = q_w.pop_front();
            if (n_checks - n_pass < 30) check_out("sb_wide", got_w, e);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[13];
    out_t prev;
    int   ft_cnt, p_cnt, wraps;
    int   p_prev, p_first, p_gap_bad, lt_prev, period, lt_cnt, lt_x;
    int   hs_cnt, hs_first, vid_cnt, vid_max;

    initial begin
        vecs[0]  = '{0,    mk(0, 0,  0,  0, 1, 1, 0, 0)};
        vecs[1]  = '{3,    mk(1, 0,  0,  0, 1, 1, 0, 0)};
        vecs[2]  = '{4,    mk(0, 1,  0,  1, 1, 1, 0, 0)};
        vecs[3]  = '{72,   mk(0, 18, 0,  0, 0, 1, 0, 0)};
        vecs[4]  = '{87,   mk(1, 21, 0,  0, 0, 1, 0, 0)};
        vecs[5]  = '{88,   mk(0, 22, 0,  0, 1, 1, 0, 0)};
        vecs[6]  = '{99,   mk(1, 24, 0,  0, 1, 1, 1, 0)};
        vecs[7]  = '{100,  mk(0, 0,  1,  1, 1, 1, 0, 0)};
        vecs[8]  = '{1200, mk(0, 0,  12, 0, 1, 0, 0, 0)};
        vecs[9]  = '{1380, mk(0, 20, 13, 0, 0, 0, 0, 0)};
        vecs[10] = '{1503, mk(1, 0,  15, 0, 1, 1, 0, 1)};
        vecs[11] = '{1699, mk(1, 24, 16, 0, 1, 1, 1, 0)};
        vecs[12] = '{1700, mk(0, 0,  0,  1, 1, 1, 0, 0)};

        rst_s = 1'b0;
        rst_w = 1'b0;
        repeat (10) @(negedge clk);
        check_out("reset_small", got_s, RST);
        check_out("reset_wide", got_w, RST);
        rst_s = 1'b1;

        for (int i = 0; i < 13; i++) begin
            while (k_s < vecs[i].k) @(negedge clk);
            check_out($sformatf("vec_k%0d", vecs[i].k), got_s, vecs[i].exp);
        end

        // Three full frames of the small mode.
        ft_cnt = 0; p_cnt = 0; wraps = 0;
        prev = got_s;
        for (int c = 0; c < 3 * 1700; c++) begin
            @(negedge clk);
            if (c < 1700 && got_s.p_tick) p_cnt++;
            if (got_s.frame_tick) begin
                ft_cnt++;
                check_int("ft_x", int'(got_s.x), 0);
                check_int("ft_y", int'(got_s.y), 15);
                check_int("ft_video", int'(got_s.video), 0);
            end
            if (prev.line_tick && prev.y == 10'd16) begin
                wraps++;
                check_int("frame_wrap_x", int'(got_s.x), 0);
                check_int("frame_wrap_y", int'(got_s.y), 0);
            end
            prev = got_s;
        end
        check_int("frame_ticks_3_frames", ft_cnt, 3);
        check_int("p_ticks_per_frame", p_cnt, 425);
        check_int("frame_wraps", wraps, 3);

        // Asynchronous reset in the middle of a frame, between clock edges.
        while (k_s < 7329) @(negedge clk);
        check_int("pre_reset_x", int'(got_s.x), 7);
        check_int("pre_reset_y", int'(got_s.y), 5);
        @(posedge clk);
        #1;
        sb_s = 1'b0;
        q_s.delete();
        rst_s = 1'b0;
        #1;
        check_out("async_reset_immediate", got_s, RST);
        repeat (5) @(negedge clk);
        check_out("reset_hold_mid", got_s, RST);
        rst_s = 1'b1;
        sb_s  = 1'b1;
        while (k_s < 3) @(negedge clk);
        check_out("restart_first_tick", got_s, mk(1, 0, 0, 0, 1, 1, 0, 0));
        @(negedge clk);
        check_out("restart_px1", got_s, mk(0, 1, 0, 1, 1, 1, 0, 0));
        repeat (1800) @(negedge clk);

        // Default timing with CLK_DIV=2: two lines, statistics taken on line 1.
        rst_w = 1'b1;
        p_prev = -1; p_first = -1; p_gap_bad = 0; lt_prev = -1; period = -1;
        lt_cnt = 0; lt_x = -1; hs_cnt = 0; hs_first = -1; vid_cnt = 0; vid_max = -1;
        for (int c = 1; c <= 3200; c++) begin
            @(negedge clk);
            if (got_w.p_tick) begin
                if (p_first < 0) p_first = k_w;
                if (p_prev >= 0 && k_w - p_prev != 2) p_gap_bad++;
                p_prev = k_w;
                if (got_w.y == 10'd1) begin
                    if (!got_w.hsync) begin
                        hs_cnt++;
                        if (hs_first < 0) hs_first = int'(got_w.x);
                    end
                    if (got_w.video) begin
                        vid_cnt++;
                        if (int'(got_w.x) > vid_max) vid_max = int'(got_w.x);
                    end
                end
            end
            if (got_w.line_tick) begin
                if (lt_prev >= 0) period = k_w - lt_prev;
                lt_prev = k_w;
                if (got_w.y == 10'd1) begin
                    lt_cnt++;
                    lt_x = int'(got_w.x);
                end
            end
        end
        check_int("wide_first_p_tick_k", p_first, 1);
        check_int("wide_p_tick_gap_errors", p_gap_bad, 0);
        check_int("wide_hsync_low_pixels", hs_cnt, 96);
        check_int("wide_hsync_first_x", hs_first, 656);
        check_int("wide_video_pixels", vid_cnt, 640);
        check_int("wide_video_last_x", vid_max, 639);
        check_int("wide_line_ticks", lt_cnt, 1);
        check_int("wide_line_tick_x", lt_x, 799);
        check_int("wide_line_period", period, 1600);
        check_int("wide_after_2_lines_x", int'(got_w.x), 0);
        check_int("wide_after_2_lines_y", int'(got_w.y), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
